// File: rtl/fpu_pkg.sv
// Shared types and constants for the fraction product engine and its unpack helper.
package fpu_pkg;

    localparam int unsigned MAN_W  = 23;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned SUM_W  = EXP_W + 2;
    localparam int unsigned CNT_W  = 5;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } fpe_state_e;

    // Signed ea+eb-BIAS; wide enough that the full range -125..381 is exact.
    function automatic logic signed [SUM_W-1:0] exp_sum(input logic [EXP_W-1:0] ea,
                                                        input logic [EXP_W-1:0] eb);
        return SUM_W'(ea) + SUM_W'(eb) - SUM_W'(BIAS);
    endfunction

endpackage

// File: rtl/fraction_product_engine_if.sv
// Operand/result handshake bundle between a producer, the engine and the normalizer.
interface fraction_product_engine_if;
    import fpu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    fp32_t            a;
    fp32_t            b;
    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] fraction;
    logic [EXP_W-1:0] exponent;
    logic             sign;
    logic             sticky;
    logic             zero;
    logic             inf_nan;
    logic             exp_ovf;
    logic             exp_unf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, fraction, exponent, sign, sticky,
               zero, inf_nan, exp_ovf, exp_unf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, fraction, exponent, sign, sticky,
               zero, inf_nan, exp_ovf, exp_unf
    );

endinterface

// File: rtl/fpu_unpack.sv
// Splits a single-precision operand into fields and classifies zero/denormal and inf/NaN.
module fpu_unpack
    import fpu_pkg::*;
(
    input  fp32_t            op,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [SIG_W-1:0] sig,
    output logic             is_zero,
    output logic             is_special
);

    assign sign       = op.sign;
    assign exp        = op.exp;
    assign sig        = {1'b1, op.man};
    assign is_zero    = (op.exp == '0);
    assign is_special = (op.exp == {EXP_W{1'b1}});

endmodule

// File: rtl/fraction_product_engine.sv
// Sequential shift-add single-precision mantissa multiplier feeding the normalizer.
module fraction_product_engine
    import fpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    fraction_product_engine_if.slave  bus
);

    localparam logic signed [SUM_W-1:0] EXP_TOP = SUM_W'(255);
    localparam logic signed [SUM_W-1:0] EXP_BOT = SUM_W'(0);

    fpe_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PROD_W-1:0]        acc_q, acc_d;
    logic [SIG_W-1:0]         mcand_q, mcand_d;
    logic [SIG_W-1:0]         mplier_q, mplier_d;
    logic signed [SUM_W-1:0]  exp_q, exp_d;
    logic                     sign_q, sign_d;
    logic                     zero_q, zero_d;
    logic                     inf_nan_q, inf_nan_d;

    logic             sa, sb, za, zb, xa, xb;
    logic [EXP_W-1:0] ea, eb;
    logic [SIG_W-1:0] ma, mb;

    fpu_unpack u_unpack_a (
        .op(bus.a), .sign(sa), .exp(ea), .sig(ma), .is_zero(za), .is_special(xa)
    );

    fpu_unpack u_unpack_b (
        .op(bus.b), .sign(sb), .exp(eb), .sig(mb), .is_zero(zb), .is_special(xb)
    );

    // Next-state and datapath updates; zero classification wins over inf/NaN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        zero_d    = zero_q;
        inf_nan_d = inf_nan_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d    = sa ^ sb;
                    exp_d     = exp_sum(ea, eb);
                    zero_d    = za | zb;
                    inf_nan_d = ~(za | zb) & (xa | xb);
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = ma;
                    mplier_d  = mb;
                    state_d   = (za | zb | xa | xb) ? DONE : MUL;
                end
            end
            MUL: begin
                if (mplier_q[cnt_q]) begin
                    acc_d = acc_q + (PROD_W'(mcand_q) << cnt_q);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MAN_W)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            zero_q    <= 1'b0;
            inf_nan_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            zero_q    <= zero_d;
            inf_nan_q <= inf_nan_d;
        end
    end

    // Result fields decode straight from registers and read as zero outside DONE.
    logic normal_path;
    assign normal_path   = bus.out_valid & ~zero_q & ~inf_nan_q;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.fraction  = bus.out_valid ? acc_q[PROD_W-1:SIG_W] : '0;
    assign bus.sticky    = bus.out_valid & (|acc_q[SIG_W-1:0]);
    assign bus.sign      = bus.out_valid & sign_q;
    assign bus.zero      = bus.out_valid & zero_q;
    assign bus.inf_nan   = bus.out_valid & inf_nan_q;
    assign bus.exponent  = !normal_path ? (bus.inf_nan ? {EXP_W{1'b1}} : '0)
                                        : exp_q[EXP_W-1:0];
    assign bus.exp_ovf   = normal_path & (exp_q >= EXP_TOP);
    assign bus.exp_unf   = normal_path & (exp_q <= EXP_BOT);

endmodule

// File: tb/tb_fraction_product_engine.sv
// Randomized and directed bench for fraction_product_engine against an arithmetic reference.
module tb_fraction_product_engine;

    typedef struct {
        logic [23:0] fraction;
        logic [7:0]  exponent;
        logic        sign;
        logic        sticky;
        logic        zero;
        logic        inf_nan;
        logic        exp_ovf;
        logic        exp_unf;
        int          latency;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fraction_product_engine_if bus ();

    fraction_product_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference: real-number style product of the significands with plain integer exponent math.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        r;
        int          ea, eb, s;
        logic [63:0] prod;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = ea + eb - 127;
        r.sign    = a[31] ^ b[31];
        r.fraction = '0;
        r.sticky  = 1'b0;
        r.zero    = 1'b0;
        r.inf_nan = 1'b0;
        r.exp_ovf = 1'b0;
        r.exp_unf = 1'b0;
        if (ea == 0 || eb == 0) begin
            r.zero     = 1'b1;
            r.exponent = 8'h00;
            r.latency  = 1;
        end else if (ea == 255 || eb == 255) begin
            r.inf_nan  = 1'b1;
            r.exponent = 8'hFF;
            r.latency  = 1;
        end else begin
            prod       = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
            r.fraction = prod[47:24];
            r.sticky   = (prod[23:0] != 24'd0);
            r.exponent = 8'(s & 255);
            r.exp_ovf  = (s >= 255);
            r.exp_unf  = (s <= 0);
            r.latency  = 24;
        end
        return r;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check({tag, ".valid"},    64'(bus.out_valid), 64'(1'b1));
        check({tag, ".fraction"}, 64'(bus.fraction),  64'(e.fraction));
        check({tag, ".exponent"}, 64'(bus.exponent),  64'(e.exponent));
        check({tag, ".sign"},     64'(bus.sign),      64'(e.sign));
        check({tag, ".sticky"},   64'(bus.sticky),    64'(e.sticky));
        check({tag, ".zero"},     64'(bus.zero),      64'(e.zero));
        check({tag, ".inf_nan"},  64'(bus.inf_nan),   64'(e.inf_nan));
        check({tag, ".exp_ovf"},  64'(bus.exp_ovf),   64'(e.exp_ovf));
        check({tag, ".exp_unf"},  64'(bus.exp_unf),   64'(e.exp_unf));
        check({tag, ".in_ready"}, 64'(bus.in_ready),  64'(1'b0));
    endtask

    task automatic start_job(input string tag, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) check({tag, ".ready_timeout"}, 64'(bus.in_ready), 64'(1'b1));
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // One job end to end: noise on the input side while busy, optional backpressure.
    task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit noise);
        exp_t e;
        int   lat;
        e   = model(a, b);
        lat = 0;
        start_job(tag, a, b);
        for (int i = 1; i <= 40; i++) begin
            bus.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = i;
                break;
            end
        end
        bus.in_valid = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(e.latency));
        check_result(tag, e);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_result({tag, ".hold"}, e);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".drop_valid"}, 64'(bus.out_valid), 64'(1'b0));
        check({tag, ".idle_ready"}, 64'(bus.in_ready),  64'(1'b1));
    endtask

    function automatic logic [7:0] rand_exp();
        case ($urandom_range(0, 9))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h01;
            3:       return 8'hFE;
            default: return 8'($urandom_range(1, 254));
        endcase
    endfunction

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready",  64'(bus.in_ready),  64'(1'b1));
        check("reset.out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("reset.fraction",  64'(bus.fraction),  64'(0));
        check("reset.exponent",  64'(bus.exponent),  64'(0));
        check("reset.flags",     64'({bus.sign, bus.sticky, bus.zero, bus.inf_nan,
                                      bus.exp_ovf, bus.exp_unf}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready with nothing pending must not disturb the idle engine
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("spurious_ready.out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("spurious_ready.in_ready",  64'(bus.in_ready),  64'(1'b1));

        run_job("one_x_one",   32'h3F800000, 32'h3F800000, 0, 1'b0);
        run_job("onehalf_sq",  32'h3FC00000, 32'h3FC00000, 0, 1'b1);
        run_job("neg_two_x3",  32'hC0000000, 32'h40400000, 0, 1'b0);
        run_job("ulp_sticky",  32'h3F800001, 32'h3F800001, 0, 1'b1);
        run_job("zero_x_pi",   32'h00000000, 32'h40490FDB, 0, 1'b1);
        run_job("zero_x_inf",  32'h80000000, 32'h7F800000, 0, 1'b0);
        run_job("ovf",         32'h7F000000, 32'h7F000000, 0, 1'b0);
        run_job("inf_x_one",   32'h7F800000, 32'h3F800000, 0, 1'b0);
        run_job("unf",         32'h00800000, 32'h00800000, 0, 1'b0);
        run_job("max_mant",    32'h3FFFFFFF, 32'hBFFFFFFF, 0, 1'b1);
        run_job("backpress",   32'h40490FDB, 32'h3FC00000, 5, 1'b1);

        // Reset in the middle of the multiply drops the job with no stray out_valid
        start_job("midreset", 32'h40400000, 32'h40400000);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset.out_valid", 64'(bus.out_valid), 64'(1'b0));
        check("midreset.fraction",  64'(bus.fraction),  64'(0));
        check("midreset.exponent",  64'(bus.exponent),  64'(0));
        check("midreset.flags",     64'({bus.sign, bus.sticky, bus.zero, bus.inf_nan,
                                        bus.exp_ovf, bus.exp_unf}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midreset.in_ready",  64'(bus.in_ready),  64'(1'b1));
        check("midreset.no_valid",  64'(bus.out_valid), 64'(1'b0));
        run_job("after_reset", 32'h40400000, 32'h40400000, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            ra = {1'($urandom_range(0, 1)), rand_exp(), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), rand_exp(), 23'($urandom)};
            run_job($sformatf("rand%0d", n), ra, rb, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
